// File: rtl/flow_table_mem_if.sv
// Flow-table memory bus between the matcher (master) and the table memory (slave).
// Transfers one byte-addressed access at a time, using a ready/err response pulse.
interface flow_table_mem_if;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [3:0]  mem_width_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        mem_ready_o;
   logic        mem_err_o;

   modport master (
      output mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
      input  mem_data_o, mem_ready_o, mem_err_o
   );

   modport slave (
      input  mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
      output mem_data_o, mem_ready_o, mem_err_o
   );
endinterface

// File: rtl/flow_table_mem.sv
// Big-endian byte array holding flow entries and counters.
// Serves fixed-latency bus accesses; the cfg port writes single bytes directly.
module flow_table_mem #(
   parameter int DEPTH_BYTES = 4096,
   parameter int LATENCY     = 2
) (
   input  logic               clk,
   input  logic               rst,
   flow_table_mem_if.slave    bus,
   input  logic               cfg_we_i,
   input  logic [31:0]        cfg_addr_i,
   input  logic [7:0]         cfg_data_i,
   output logic [31:0]        rd_cnt_o,
   output logic [31:0]        wr_cnt_o
);

   localparam int         AW  = $clog2(DEPTH_BYTES);
   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  lat_q, lat_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  width_q, width_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;

   logic [7:0]    mem_q [DEPTH_BYTES];

   logic          width_ok;
   logic          range_ok;
   logic          acc_err;
   logic          complete;
   logic [32:0]   end_addr;
   logic [AW-1:0] idx [4];
   logic [7:0]    rd_byte [4];
   logic [31:0]   rd_word;
   logic [3:0]    wr_en;
   logic [7:0]    wr_byte [4];
   logic          cfg_hit;

   // The end address is computed in 33 bits so a request near 2^32 cannot wrap back into range.
   always_comb begin
      width_ok = (width_q == 4'd1) || (width_q == 4'd2) || (width_q == 4'd4);
      end_addr = {1'b0, addr_q} + {29'd0, width_q};
      range_ok = (end_addr <= 33'(DEPTH_BYTES));
      acc_err  = !(width_ok && range_ok);
      complete = (state_q == BUSY) && (lat_q == LAT);
      cfg_hit  = cfg_we_i && (cfg_addr_i < 32'(DEPTH_BYTES));
      wr_en    = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         idx[i]     = addr_q[AW-1:0] + AW'(i);
         rd_byte[i] = mem_q[idx[i]];
         wr_byte[i] = 8'h00;
      end
      case (width_q)
         4'd1:    rd_word = {24'h0, rd_byte[0]};
         4'd2:    rd_word = {16'h0, rd_byte[0], rd_byte[1]};
         default: rd_word = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
      endcase
      if (complete && we_q && !acc_err) begin
         case (width_q)
            4'd1: begin
               wr_en      = 4'b0001;
               wr_byte[0] = wdata_q[7:0];
            end
            4'd2: begin
               wr_en      = 4'b0011;
               wr_byte[0] = wdata_q[15:8];
               wr_byte[1] = wdata_q[7:0];
            end
            default: begin
               wr_en      = 4'b1111;
               wr_byte[0] = wdata_q[31:24];
               wr_byte[1] = wdata_q[23:16];
               wr_byte[2] = wdata_q[15:8];
               wr_byte[3] = wdata_q[7:0];
            end
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      we_d     = we_q;
      addr_d   = addr_q;
      width_d  = width_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.mem_ce_i) begin
               we_d    = bus.mem_we_i;
               addr_d  = bus.mem_addr_i;
               width_d = bus.mem_width_i;
               wdata_d = bus.mem_data_i;
               lat_d   = 4'd1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (complete) begin
               ready_d = 1'b1;
               state_d = RESP;
               if (acc_err) begin
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
               end else if (we_q) begin
                  if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_d = wr_cnt_q + 32'd1;
               end else begin
                  rdata_d = rd_word;
                  if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_d = rd_cnt_q + 32'd1;
               end
            end else begin
               lat_d = lat_q + 4'd1;
            end
         end
         // The bus is deliberately not sampled here, so an address advanced on ready is seen fresh.
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         lat_q    <= 4'd0;
         we_q     <= 1'b0;
         addr_q   <= 32'h0;
         width_q  <= 4'd0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         rd_cnt_q <= 32'h0;
         wr_cnt_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         width_q  <= width_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   // Array is never reset; bus bytes are written after the cfg byte so the bus wins a collision.
   always_ff @(posedge clk) begin
      if (cfg_hit) mem_q[cfg_addr_i[AW-1:0]] <= cfg_data_i;
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) mem_q[idx[i]] <= wr_byte[i];
      end
   end

   assign bus.mem_data_o  = rdata_q;
   assign bus.mem_ready_o = ready_q;
   assign bus.mem_err_o   = err_q;
   assign rd_cnt_o        = rd_cnt_q;
   assign wr_cnt_o        = wr_cnt_q;

endmodule

// File: tb/tb_flow_table_mem.sv
// Directed self-checking bench for flow_table_mem: timing, byte order, errors,
// cfg/bus collisions, reset mid-access and counter saturation.
module tb_flow_table_mem;

   localparam int LAT   = 2;
   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [31:0] cfg_addr;
   logic [7:0]  cfg_data;
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;

   int          checks   = 0;
   int          failures = 0;

   logic [31:0] rdata;
   logic        err;
   int          cyc;
   logic [7:0]  b;

   flow_table_mem_if bus();

   flow_table_mem #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .cfg_we_i   (cfg_we),
      .cfg_addr_i (cfg_addr),
      .cfg_data_i (cfg_data),
      .rd_cnt_o   (rd_cnt),
      .wr_cnt_o   (wr_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic cfgWrite(input logic [31:0] a, input logic [7:0] d);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   // One bus access; cycles counts edges from the capture edge up to the ready edge inclusive.
   task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [3:0] w,
                                input logic [31:0] d, output logic [31:0] rd,
                                output logic er, output int cycles);
      @(negedge clk);
      bus.mem_ce_i    = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_addr_i  = a;
      bus.mem_width_i = w;
      bus.mem_data_i  = d;
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!bus.mem_ready_o && cycles < 20);
      bus.mem_ce_i = 1'b0;
      checkOutput("ready_seen", {31'd0, bus.mem_ready_o}, 32'd1);
      rd = bus.mem_data_o;
      er = bus.mem_err_o;
      @(posedge clk);
      #1;
      checkOutput("ready_one_cycle", {31'd0, bus.mem_ready_o}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst             = 1'b0;
      cfg_we          = 1'b0;
      cfg_addr        = 32'h0;
      cfg_data        = 8'h0;
      bus.mem_ce_i    = 1'b0;
      bus.mem_we_i    = 1'b0;
      bus.mem_addr_i  = 32'h0;
      bus.mem_width_i = 4'd0;
      bus.mem_data_i  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_data",  bus.mem_data_o, 32'h0);
      checkOutput("rst_ready", {31'd0, bus.mem_ready_o}, 32'd0);
      checkOutput("rst_err",   {31'd0, bus.mem_err_o}, 32'd0);
      checkOutput("rst_rdcnt", rd_cnt, 32'h0);
      checkOutput("rst_wrcnt", wr_cnt, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      $display("[TB] basic read");
      cfgWrite(32'h100, 8'hAA);
      cfgWrite(32'h101, 8'hBB);
      cfgWrite(32'h102, 8'hCC);
      cfgWrite(32'h103, 8'hDD);
      applyStimulus(1'b0, 32'h100, 4'd4, 32'h0, rdata, err, cyc);
      checkOutput("t1_latency", 32'(cyc), 32'(LAT + 1));
      checkOutput("t1_data", rdata, 32'hAABBCCDD);
      checkOutput("t1_err", {31'd0, err}, 32'd0);
      checkOutput("t1_rdcnt", rd_cnt, 32'd1);

      $display("[TB] write then read back");
      applyStimulus(1'b1, 32'h101, 4'd2, 32'h0000_1234, rdata, err, cyc);
      checkOutput("t2_wr_err", {31'd0, err}, 32'd0);
      checkOutput("t2_data_held", rdata, 32'hAABBCCDD);
      checkOutput("t2_wrcnt", wr_cnt, 32'd1);
      applyStimulus(1'b0, 32'h100, 4'd4, 32'h0, rdata, err, cyc);
      checkOutput("t2_rd_w4", rdata, 32'hAA1234DD);
      applyStimulus(1'b0, 32'h103, 4'd1, 32'h0, rdata, err, cyc);
      checkOutput("t2_rd_w1", rdata, 32'h0000_00DD);
      applyStimulus(1'b0, 32'h101, 4'd2, 32'h0, rdata, err, cyc);
      checkOutput("t2_rd_w2", rdata, 32'h0000_1234);
      checkOutput("t2_rdcnt", rd_cnt, 32'd4);

      $display("[TB] streaming reads with ce held");
      for (int i = 0; i < 16; i++) cfgWrite(32'h400 + 32'(i), 8'h10 + 8'(i));
      @(negedge clk);
      bus.mem_ce_i    = 1'b1;
      bus.mem_we_i    = 1'b0;
      bus.mem_width_i = 4'd4;
      bus.mem_addr_i  = 32'h400;
      for (int w = 0; w < 4; w++) begin
         cyc = 0;
         do begin
            @(posedge clk);
            #1;
            cyc++;
         end while (!bus.mem_ready_o && cyc < 20);
         checkOutput("t3_ready", {31'd0, bus.mem_ready_o}, 32'd1);
         checkOutput("t3_interval", 32'(cyc), (w == 0) ? 32'(LAT + 1) : 32'(LAT + 2));
         b = 8'h10 + 8'(4 * w);
         checkOutput("t3_word", bus.mem_data_o, {b, b + 8'd1, b + 8'd2, b + 8'd3});
         if (w < 3) bus.mem_addr_i = bus.mem_addr_i + 32'd4;
         else       bus.mem_ce_i   = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput("t3_rdcnt", rd_cnt, 32'd8);

      $display("[TB] error cases");
      applyStimulus(1'b0, 32'd4094, 4'd4, 32'h0, rdata, err, cyc);
      checkOutput("t4_oob_err", {31'd0, err}, 32'd1);
      checkOutput("t4_oob_data", rdata, 32'h0);
      checkOutput("t4_oob_rdcnt", rd_cnt, 32'd8);
      applyStimulus(1'b0, 32'h0, 4'd3, 32'h0, rdata, err, cyc);
      checkOutput("t4_w3_err", {31'd0, err}, 32'd1);
      applyStimulus(1'b1, 32'h0, 4'd0, 32'hDEAD_BEEF, rdata, err, cyc);
      checkOutput("t4_w0_err", {31'd0, err}, 32'd1);
      checkOutput("t4_wrcnt", wr_cnt, 32'd1);
      applyStimulus(1'b0, 32'hFFFF_FFFE, 4'd4, 32'h0, rdata, err, cyc);
      checkOutput("t4_wrap_err", {31'd0, err}, 32'd1);
      cfgWrite(32'h0, 8'h77);
      cfgWrite(32'd4096, 8'hEE);
      cfgWrite(32'd4092, 8'h01);
      cfgWrite(32'd4093, 8'h02);
      cfgWrite(32'd4094, 8'h03);
      cfgWrite(32'd4095, 8'h04);
      applyStimulus(1'b0, 32'd4092, 4'd4, 32'h0, rdata, err, cyc);
      checkOutput("t4_edge_err", {31'd0, err}, 32'd0);
      checkOutput("t4_edge_data", rdata, 32'h0102_0304);
      applyStimulus(1'b0, 32'h0, 4'd1, 32'h0, rdata, err, cyc);
      checkOutput("t4_cfg_oob_dropped", rdata, 32'h0000_0077);
      checkOutput("t4_rdcnt", rd_cnt, 32'd10);

      $display("[TB] bus write beats same-edge cfg write");
      @(negedge clk);
      bus.mem_ce_i    = 1'b1;
      bus.mem_we_i    = 1'b1;
      bus.mem_addr_i  = 32'h200;
      bus.mem_width_i = 4'd4;
      bus.mem_data_i  = 32'h1122_3344;
      @(posedge clk);
      @(negedge clk);
      bus.mem_ce_i = 1'b0;
      for (int i = 1; i < LAT; i++) @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = 32'h201;
      cfg_data = 8'h55;
      @(posedge clk);
      #1;
      checkOutput("t5_commit_ready", {31'd0, bus.mem_ready_o}, 32'd1);
      @(negedge clk);
      cfg_we = 1'b0;
      applyStimulus(1'b0, 32'h200, 4'd4, 32'h0, rdata, err, cyc);
      checkOutput("t5_data", rdata, 32'h1122_3344);
      checkOutput("t5_wrcnt", wr_cnt, 32'd2);

      $display("[TB] reset during busy write");
      for (int i = 0; i < 4; i++) cfgWrite(32'h300 + 32'(i), 8'h00);
      @(negedge clk);
      bus.mem_ce_i    = 1'b1;
      bus.mem_we_i    = 1'b1;
      bus.mem_addr_i  = 32'h300;
      bus.mem_width_i = 4'd4;
      bus.mem_data_i  = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      rst          = 1'b0;
      bus.mem_ce_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checkOutput("t6_no_ready", {31'd0, bus.mem_ready_o}, 32'd0);
      end
      checkOutput("t6_rdcnt", rd_cnt, 32'h0);
      checkOutput("t6_wrcnt", wr_cnt, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, 32'h300, 4'd4, 32'h0, rdata, err, cyc);
      checkOutput("t6_no_commit", rdata, 32'h0);
      checkOutput("t6_rdcnt_after", rd_cnt, 32'd1);

      $display("[TB] read counter saturation");
      @(negedge clk);
      force dut.rd_cnt_q = 32'hFFFF_FFFE;
      @(posedge clk);
      #1;
      release dut.rd_cnt_q;
      checkOutput("sat_preset", rd_cnt, 32'hFFFF_FFFE);
      applyStimulus(1'b0, 32'h100, 4'd1, 32'h0, rdata, err, cyc);
      checkOutput("sat_reach", rd_cnt, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 32'h100, 4'd1, 32'h0, rdata, err, cyc);
      checkOutput("sat_hold", rd_cnt, 32'hFFFF_FFFF);
      checkOutput("sat_data", rdata, 32'h0000_00AA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
